// File: rtl/issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : issue_unit
//  Description : Issue scheduler for the integer, ld/st, multiply and divide
//                queues. It grants ready queue heads so that every result
//                lands on the single common data bus in a cycle that no other
//                unit owns. CDB ownership is tracked with a slot-reservation
//                shift register, and the non-pipelined divider with a busy
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_unit #(
    parameter int MUL_LATENCY = 4,   // 2 .. DIV_LATENCY-1
    parameter int DIV_LATENCY = 7    // MUL_LATENCY+1 .. 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       issueque_integer_ready,
    input  logic       issueque_ld_st_ready,
    input  logic       issueque_mul_ready,
    input  logic       issueque_div_ready,
    output logic       issue_integer,
    output logic       issue_ld_st,
    output logic       issue_mul,
    output logic       issue_div,
    output logic       div_busy,
    output logic       cdb_valid,
    output logic [1:0] cdb_sel
);

    localparam logic [1:0] c_OWN_INT   = 2'b00;
    localparam logic [1:0] c_OWN_LD_ST = 2'b01;
    localparam logic [1:0] c_OWN_MUL   = 2'b10;
    localparam logic [1:0] c_OWN_DIV   = 2'b11;
    localparam logic [3:0] c_DIV_LOAD  = 4'(DIV_LATENCY - 1);

    // Reservation slot k means "CDB owned k-1 cycles from now". Free slots
    // always carry owner 00, so slot 1's owner can drive cdb_sel directly.
    logic [DIV_LATENCY:1]      r_valid;
    logic [DIV_LATENCY:1][1:0] r_owner;
    logic [3:0]                r_div_cnt;
    logic                      r_lru;      // 0: integer wins a tie with ld/st

    logic                      w_issue_int;
    logic                      w_issue_ls;
    logic                      w_issue_mul;
    logic                      w_issue_div;
    logic [DIV_LATENCY:1]      w_valid_nxt;
    logic [DIV_LATENCY:1][1:0] w_owner_nxt;
    logic [3:0]                w_div_cnt_nxt;
    logic                      w_lru_nxt;

    // Grant decision: each unit checks the slot its result will occupy after
    // this cycle's shift. The div slot (DIV_LATENCY+1) is always free, so the
    // divider is gated only by its busy counter.
    always_comb begin
        w_issue_int = 1'b0;
        w_issue_ls  = 1'b0;
        w_issue_mul = 1'b0;
        w_issue_div = 1'b0;
        if (!reset) begin
            w_issue_div = issueque_div_ready & (r_div_cnt == 4'd0);
            w_issue_mul = issueque_mul_ready & ~r_valid[MUL_LATENCY+1];
            if (!r_valid[2]) begin
                if (issueque_integer_ready && issueque_ld_st_ready) begin
                    w_issue_int = ~r_lru;
                    w_issue_ls  = r_lru;
                end else begin
                    w_issue_int = issueque_integer_ready;
                    w_issue_ls  = issueque_ld_st_ready;
                end
            end
        end
    end

    // Next reservation state: advance every slot by one, then claim the
    // slots of this cycle's grants. The claimed indices 1, MUL_LATENCY and
    // DIV_LATENCY are distinct, so marks never collide.
    always_comb begin
        w_valid_nxt = {1'b0, r_valid[DIV_LATENCY:2]};
        w_owner_nxt = {c_OWN_INT, r_owner[DIV_LATENCY:2]};
        if (w_issue_int) begin
            w_valid_nxt[1] = 1'b1;
            w_owner_nxt[1] = c_OWN_INT;
        end
        if (w_issue_ls) begin
            w_valid_nxt[1] = 1'b1;
            w_owner_nxt[1] = c_OWN_LD_ST;
        end
        if (w_issue_mul) begin
            w_valid_nxt[MUL_LATENCY] = 1'b1;
            w_owner_nxt[MUL_LATENCY] = c_OWN_MUL;
        end
        if (w_issue_div) begin
            w_valid_nxt[DIV_LATENCY] = 1'b1;
            w_owner_nxt[DIV_LATENCY] = c_OWN_DIV;
        end
    end

    // Divider occupancy counter and int/ld-st tie-break flag.
    always_comb begin
        w_div_cnt_nxt = r_div_cnt;
        if (w_issue_div) begin
            w_div_cnt_nxt = c_DIV_LOAD;
        end else if (r_div_cnt != 4'd0) begin
            w_div_cnt_nxt = r_div_cnt - 4'd1;
        end
        w_lru_nxt = r_lru;
        if (w_issue_int) begin
            w_lru_nxt = 1'b1;
        end else if (w_issue_ls) begin
            w_lru_nxt = 1'b0;
        end
    end

    // State registers; reset discards every pending reservation.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid   <= '0;
            r_owner   <= '0;
            r_div_cnt <= 4'd0;
            r_lru     <= 1'b0;
        end else begin
            r_valid   <= w_valid_nxt;
            r_owner   <= w_owner_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_lru     <= w_lru_nxt;
        end
    end

    assign issue_integer = w_issue_int;
    assign issue_ld_st   = w_issue_ls;
    assign issue_mul     = w_issue_mul;
    assign issue_div     = w_issue_div;
    assign div_busy      = (r_div_cnt != 4'd0);
    assign cdb_valid     = r_valid[1];
    assign cdb_sel       = r_owner[1];

endmodule
`default_nettype wire

// File: tb/tb_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_unit
//  Description : Self-checking bench for issue_unit. Grants are checked
//                inline per scenario; expected CDB ownership is queued by
//                absolute cycle number and compared every cycle by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_unit;

    logic       clk;
    logic       reset;
    logic       int_rdy, ls_rdy, mul_rdy, div_rdy;
    logic       issue_integer, issue_ld_st, issue_mul, issue_div;
    logic       div_busy, cdb_valid;
    logic [1:0] cdb_sel;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 0;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
    } exp_t;
    exp_t exp_q[$];

    issue_unit #(.MUL_LATENCY(4), .DIV_LATENCY(7)) dut (
        .clock                  (clk),
        .reset                  (reset),
        .issueque_integer_ready (int_rdy),
        .issueque_ld_st_ready   (ls_rdy),
        .issueque_mul_ready     (mul_rdy),
        .issueque_div_ready     (div_rdy),
        .issue_integer          (issue_integer),
        .issue_ld_st            (issue_ld_st),
        .issue_mul              (issue_mul),
        .issue_div              (issue_div),
        .div_busy               (div_busy),
        .cdb_valid              (cdb_valid),
        .cdb_sel                (cdb_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Insert an expected CDB owner keeping the queue ordered by cycle.
    task automatic push_cdb(input int c, input logic [1:0] s);
        exp_t e;
        int   i;
        e.cyc = c;
        e.sel = s;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
        exp_q.insert(i, e);
    endtask

    // Scoreboard monitor: every out-of-reset cycle the CDB must match the
    // queued owner for that cycle, or be idle with sel 00.
    always @(negedge clk) begin
        if (mon_en && reset === 1'b0) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL cdb_missed cycle=%0d expected sel=%b", exp_q[0].cyc, exp_q[0].sel);
                void'(exp_q.pop_front());
            end
            checks++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                if (cdb_valid !== 1'b1 || cdb_sel !== exp_q[0].sel) begin
                    errors++;
                    $display("FAIL cdb_owner cycle=%0d got valid=%b sel=%b expected valid=1 sel=%b",
                             cyc, cdb_valid, cdb_sel, exp_q[0].sel);
                end
                void'(exp_q.pop_front());
            end else begin
                if (cdb_valid !== 1'b0 || cdb_sel !== 2'b00) begin
                    errors++;
                    $display("FAIL cdb_idle cycle=%0d got valid=%b sel=%b expected valid=0 sel=00",
                             cyc, cdb_valid, cdb_sel);
                end
            end
        end
    end

    task automatic idle_inputs();
        int_rdy = 1'b0;
        ls_rdy  = 1'b0;
        mul_rdy = 1'b0;
        div_rdy = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        exp_q.delete();
        next_cycle();
        next_cycle();
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic run_idle(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        int_rdy = 1'b1; ls_rdy = 1'b1; mul_rdy = 1'b1; div_rdy = 1'b1;
        reset = 1'b1;
        exp_q.delete();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({issue_integer, issue_ld_st, issue_mul, issue_div} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_grants got %b expected 0000",
                     {issue_integer, issue_ld_st, issue_mul, issue_div});
        end
        checks++;
        if (cdb_valid !== 1'b0 || cdb_sel !== 2'b00 || div_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got valid=%b sel=%b busy=%b expected 0 00 0",
                     cdb_valid, cdb_sel, div_busy);
        end
        next_cycle();
        idle_inputs();
        reset  = 1'b0;
        mon_en = 1'b1;
        run_idle(2);
    endtask

    task automatic test_int_stream();
        int t0;
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            int_rdy = 1'b1;
            push_cdb(t0 + k + 1, 2'b00);
            @(negedge clk);
            checks++;
            if (issue_integer !== 1'b1 || issue_ld_st !== 1'b0) begin
                errors++;
                $display("FAIL int_stream k=%0d got int=%b ls=%b expected int=1 ls=0",
                         k, issue_integer, issue_ld_st);
            end
            next_cycle();
        end
        run_idle(3);
    endtask

    task automatic test_alternate();
        int         t0;
        logic [3:0] exp_int;
        exp_int = 4'b0101;   // bit k: integer expected in cycle k
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            int_rdy = 1'b1;
            ls_rdy  = 1'b1;
            push_cdb(t0 + k + 1, exp_int[k] ? 2'b00 : 2'b01);
            @(negedge clk);
            checks++;
            if (issue_integer !== exp_int[k] || issue_ld_st !== ~exp_int[k]) begin
                errors++;
                $display("FAIL alternate k=%0d got int=%b ls=%b expected int=%b ls=%b",
                         k, issue_integer, issue_ld_st, exp_int[k], ~exp_int[k]);
            end
            next_cycle();
        end
        run_idle(3);
    endtask

    task automatic test_mul_block();
        int t0;
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            if (k == 0) mul_rdy = 1'b1;
            if (k >= 3) int_rdy = 1'b1;
            if (k == 0) push_cdb(t0 + 4, 2'b10);
            if (k == 4) push_cdb(t0 + 5, 2'b00);
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (issue_mul !== 1'b1) begin
                    errors++;
                    $display("FAIL mul_grant got %b expected 1", issue_mul);
                end
            end
            if (k >= 3) begin
                checks++;
                if (issue_integer !== (k == 4)) begin
                    errors++;
                    $display("FAIL int_behind_mul k=%0d got %b expected %b",
                             k, issue_integer, (k == 4));
                end
            end
            next_cycle();
        end
        run_idle(3);
    endtask

    task automatic test_div();
        int t0;
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 14; k++) begin
            div_rdy = 1'b1;
            mul_rdy = (k == 3 || k == 4);
            if (k == 0 || k == 7) push_cdb(t0 + k + 7, 2'b11);
            if (k == 4) push_cdb(t0 + 8, 2'b10);
            @(negedge clk);
            checks++;
            if (issue_div !== (k == 0 || k == 7) || div_busy !== !(k == 0 || k == 7)) begin
                errors++;
                $display("FAIL div_seq k=%0d got issue=%b busy=%b expected issue=%b busy=%b",
                         k, issue_div, div_busy, (k == 0 || k == 7), !(k == 0 || k == 7));
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (issue_mul !== (k == 4)) begin
                    errors++;
                    $display("FAIL mul_behind_div k=%0d got %b expected %b",
                             k, issue_mul, (k == 4));
                end
            end
            next_cycle();
        end
        run_idle(9);
    endtask

    task automatic test_simultaneous();
        int t0;
        do_reset();
        t0 = cyc;
        int_rdy = 1'b1; mul_rdy = 1'b1; div_rdy = 1'b1;
        push_cdb(t0 + 1, 2'b00);
        push_cdb(t0 + 4, 2'b10);
        push_cdb(t0 + 7, 2'b11);
        @(negedge clk);
        checks++;
        if ({issue_integer, issue_ld_st, issue_mul, issue_div} !== 4'b1011) begin
            errors++;
            $display("FAIL simultaneous got %b expected 1011",
                     {issue_integer, issue_ld_st, issue_mul, issue_div});
        end
        next_cycle();
        run_idle(9);
    endtask

    task automatic test_reset_mid();
        int t0;
        do_reset();
        t0 = cyc;
        div_rdy = 1'b1;
        push_cdb(t0 + 7, 2'b11);
        @(negedge clk);
        checks++;
        if (issue_div !== 1'b1) begin
            errors++;
            $display("FAIL mid_div_grant got %b expected 1", issue_div);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got %b expected 1", div_busy);
        end
        next_cycle();
        reset = 1'b1;          // cycle 2
        exp_q.delete();
        next_cycle();
        reset   = 1'b0;        // cycle 3
        div_rdy = 1'b1;
        push_cdb(t0 + 10, 2'b11);
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b0 || cdb_valid !== 1'b0 || issue_div !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got busy=%b valid=%b issue_div=%b expected 0 0 1",
                     div_busy, cdb_valid, issue_div);
        end
        next_cycle();
        idle_inputs();
        for (int k = 4; k < 12; k++) begin
            @(negedge clk);
            if (k == 7) begin
                checks++;
                if (cdb_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL discarded_slot got valid=%b expected 0", cdb_valid);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        test_reset();
        test_int_stream();
        test_alternate();
        test_mul_block();
        test_div();
        test_simultaneous();
        test_reset_mid();
        run_idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
